// File: rtl/partition_exec_core_if.sv
// rtl/partition_exec_core_if.sv - instruction fetch and EMIT bus between the core and its loader/scoreboard
interface partition_exec_core_if;
    logic [7:0]  instr_addr;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        emit_valid;
    logic [7:0]  emit_a;
    logic [7:0]  emit_b;

    modport master (
        output instr_addr, instr_ready, emit_valid, emit_a, emit_b,
        input  instr_valid, instr_data
    );

    modport slave (
        input  instr_addr, instr_ready, emit_valid, emit_a, emit_b,
        output instr_valid, instr_data
    );
endinterface

// File: rtl/partition_exec_core.sv
// rtl/partition_exec_core.sv - partition/XOR execution core with PNEW dedup scan, mu accounting and state hash
module partition_exec_core #(
    parameter int DATA_W      = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int MAX_MODULES = 64,
    parameter int REGION_W    = 64,
    parameter int MU_W        = 64,
    parameter int TIMEOUT     = 10000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    partition_exec_core_if.master bus,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timed_out,
    output logic                  o_table_full,
    output logic [MU_W-1:0]       o_mu_discovery,
    output logic [MU_W-1:0]       o_mu_total,
    output logic [31:0]           o_step_count,
    output logic [31:0]           o_num_modules,
    output logic [255:0]          o_final_hash
);
    localparam int          AW     = $clog2(MEM_DEPTH);
    localparam int          TW     = $clog2(MAX_MODULES);
    localparam logic [31:0] MAXM_L = MAX_MODULES;
    localparam logic [31:0] TOUT_L = TIMEOUT;

    localparam logic [7:0] OP_PNEW = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h0A;
    localparam logic [7:0] OP_ADD  = 8'h0B;
    localparam logic [7:0] OP_SWAP = 8'h0C;
    localparam logic [7:0] OP_EMIT = 8'h0E;
    localparam logic [7:0] OP_HALT = 8'hFF;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_FETCH, S_EXEC, S_SCAN, S_COMMIT, S_HASH, S_DONE, S_TOUT
    } state_t;

    state_t              r_state;
    logic [7:0]          r_pc;
    logic [7:0]          r_op;
    logic [7:0]          r_op_a;
    logic [7:0]          r_op_b;
    logic [AW-1:0]       r_init_addr;
    logic [31:0]         r_step_count;
    logic [31:0]         r_num_modules;
    logic [31:0]         r_next_id;
    logic [31:0]         r_scan_j;
    logic [MU_W-1:0]     r_mu;
    logic                r_table_full;
    logic                r_match;
    logic [REGION_W-1:0] r_new_mask;
    logic [2:0]          r_hash_k;
    logic [255:0]        r_hash;
    logic                r_emit_valid;
    logic [7:0]          r_emit_a;
    logic [7:0]          r_emit_b;
    // Entry ids always equal their index (next_id advances with num_modules), so only masks are stored.
    logic [REGION_W-1:0] r_tbl_mask [MAX_MODULES];
    logic [DATA_W-1:0]   r_mem [MEM_DEPTH];

    logic [AW-1:0]       w_addr_a;
    logic [AW-1:0]       w_addr_b;
    logic [DATA_W-1:0]   w_mem_a;
    logic [DATA_W-1:0]   w_mem_b;
    logic [REGION_W-1:0] w_pnew_mask;
    logic [TW-1:0]       w_scan_idx;
    logic [TW-1:0]       w_ins_idx;
    logic                w_scan_hit;
    state_t              w_retire_state;
    logic [31:0]         w_hash_src;
    logic [31:0]         w_mask1;
    logic                w_unused;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] w;
        w = x ^ (x << 13);
        w = w ^ (w >> 17);
        w = w ^ (w << 5);
        return w;
    endfunction

    assign w_addr_a    = AW'(r_op_a);
    assign w_addr_b    = AW'(r_op_b);
    assign w_mem_a     = r_mem[w_addr_a];
    assign w_mem_b     = r_mem[w_addr_b];
    assign w_pnew_mask = REGION_W'(1) << (32'(r_op_a) % 32'(REGION_W));
    assign w_scan_idx  = TW'(r_scan_j);
    assign w_ins_idx   = TW'(r_num_modules);
    assign w_scan_hit  = (r_tbl_mask[w_scan_idx] == r_new_mask);
    assign w_unused    = &{1'b0, bus.instr_data[7:0]};

    // Step count doubles as the timeout instruction counter; both clear in INIT and advance on retire.
    assign w_retire_state = ((r_step_count + 32'd1) == TOUT_L) ? S_TOUT : S_FETCH;

    always_comb begin
        w_hash_src = '0;
        w_mask1    = (r_num_modules == 32'd1) ? 32'd0 : 32'(r_tbl_mask[1]);
        case (r_hash_k)
            3'd0:    w_hash_src = 32'(r_pc) ^ r_next_id;
            3'd1:    w_hash_src = r_num_modules ^ r_step_count;
            3'd2:    w_hash_src = 32'(r_mu);
            3'd3:    w_hash_src = 32'(r_mu);
            3'd4:    w_hash_src = 32'(r_tbl_mask[0]);
            3'd5:    w_hash_src = w_mask1;
            3'd6:    w_hash_src = 32'(r_mem[0]);
            default: w_hash_src = 32'(r_mem[1]);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_pc          <= '0;
            r_op          <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_init_addr   <= '0;
            r_step_count  <= '0;
            r_num_modules <= 32'd1;
            r_next_id     <= 32'd1;
            r_scan_j      <= '0;
            r_mu          <= MU_W'(1);
            r_table_full  <= 1'b0;
            r_match       <= 1'b0;
            r_new_mask    <= '0;
            r_hash_k      <= '0;
            r_hash        <= '0;
            r_emit_valid  <= 1'b0;
            r_emit_a      <= '0;
            r_emit_b      <= '0;
            for (int i = 0; i < MAX_MODULES; i++) r_tbl_mask[i] <= '0;
            r_tbl_mask[0] <= REGION_W'(1);
        end else begin
            r_emit_valid <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_TOUT: begin
                    if (i_start) begin
                        r_state     <= S_INIT;
                        r_init_addr <= '0;
                    end
                end
                S_INIT: begin
                    r_init_addr <= r_init_addr + AW'(1);
                    // Architectural state is rebuilt only on the last clear cycle so results stay visible until then.
                    if (r_init_addr == AW'(MEM_DEPTH - 1)) begin
                        r_pc          <= '0;
                        r_step_count  <= '0;
                        r_table_full  <= 1'b0;
                        r_num_modules <= 32'd1;
                        r_next_id     <= 32'd1;
                        r_mu          <= MU_W'(1);
                        for (int i = 0; i < MAX_MODULES; i++) r_tbl_mask[i] <= '0;
                        r_tbl_mask[0] <= REGION_W'(1);
                        r_state       <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_op    <= bus.instr_data[31:24];
                        r_op_a  <= bus.instr_data[23:16];
                        r_op_b  <= bus.instr_data[15:8];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (r_op)
                        OP_HALT: begin
                            r_hash_k <= '0;
                            r_state  <= S_HASH;
                        end
                        OP_PNEW: begin
                            r_new_mask <= w_pnew_mask;
                            r_scan_j   <= '0;
                            r_match    <= 1'b0;
                            r_state    <= S_SCAN;
                        end
                        default: begin
                            if (r_op == OP_EMIT) begin
                                r_emit_valid <= 1'b1;
                                r_emit_a     <= r_op_a;
                                r_emit_b     <= r_op_b;
                            end
                            r_pc         <= r_pc + 8'd1;
                            r_step_count <= r_step_count + 32'd1;
                            r_state      <= w_retire_state;
                        end
                    endcase
                end
                S_SCAN: begin
                    if (w_scan_hit) begin
                        r_match <= 1'b1;
                        r_state <= S_COMMIT;
                    end else if ((r_scan_j + 32'd1) == r_num_modules) begin
                        r_state <= S_COMMIT;
                    end else begin
                        r_scan_j <= r_scan_j + 32'd1;
                    end
                end
                S_COMMIT: begin
                    if (!r_match) begin
                        if (r_num_modules < MAXM_L) begin
                            r_tbl_mask[w_ins_idx] <= r_new_mask;
                            r_next_id             <= r_next_id + 32'd1;
                            r_num_modules         <= r_num_modules + 32'd1;
                            r_mu                  <= r_mu + MU_W'(1);
                        end else begin
                            r_table_full <= 1'b1;
                        end
                    end
                    r_pc         <= r_pc + 8'd1;
                    r_step_count <= r_step_count + 32'd1;
                    r_state      <= w_retire_state;
                end
                S_HASH: begin
                    r_hash[{r_hash_k, 5'b00000} +: 32] <= xs32(w_hash_src);
                    r_hash_k <= r_hash_k + 3'd1;
                    if (r_hash_k == 3'd7) r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Data memory has no reset; INIT clears it before every run.
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_addr] <= '0;
        end else if (r_state == S_EXEC) begin
            case (r_op)
                OP_LOAD: r_mem[w_addr_a] <= DATA_W'(r_op_b);
                OP_ADD:  r_mem[w_addr_a] <= w_mem_a ^ w_mem_b;
                OP_SWAP: begin
                    r_mem[w_addr_a] <= w_mem_b;
                    r_mem[w_addr_b] <= w_mem_a;
                end
                default: ;
            endcase
        end
    end

    assign bus.instr_addr  = r_pc;
    assign bus.instr_ready = (r_state == S_FETCH);
    assign bus.emit_valid  = r_emit_valid;
    assign bus.emit_a      = r_emit_a;
    assign bus.emit_b      = r_emit_b;

    assign o_busy          = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_TOUT);
    assign o_done          = (r_state == S_DONE);
    assign o_timed_out     = (r_state == S_TOUT);
    assign o_table_full    = r_table_full;
    assign o_mu_discovery  = r_mu;
    assign o_mu_total      = r_mu;
    assign o_step_count    = r_step_count;
    assign o_num_modules   = r_num_modules;
    assign o_final_hash    = r_hash;
endmodule
